// File: rtl/switch_pkg.sv
// Shared types and helpers for the serially configured routing switch.
package switch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2
   } sb_state_t;

   // One routing field is {en, sel}.
   function automatic int fld_w(input int inputs);
      return $clog2(inputs) + 1;
   endfunction

endpackage

// File: rtl/switch_box_cell.sv
// One routed output: selects one input bus when enabled, otherwise drives zero.
module switch_box_cell #(
   parameter int INPUTS = 8,
   parameter int WIDTH  = 1,
   parameter int FLD_W  = 4
) (
   input  logic [FLD_W-1:0] fld_i,
   input  logic [WIDTH-1:0] in_data_i [INPUTS],
   output logic [WIDTH-1:0] out_o
);

   localparam int SEL_W = FLD_W - 1;

   logic [SEL_W-1:0] sel;
   assign sel = fld_i[SEL_W-1:0];

   // A select at or beyond INPUTS matches no index and leaves the output at zero.
   always_comb begin
      out_o = '0;
      if (fld_i[FLD_W-1]) begin
         for (int i = 0; i < INPUTS; i++) begin
            if (sel == SEL_W'(i)) out_o = in_data_i[i];
         end
      end
   end

endmodule

// File: rtl/switch_box.sv
// Routing switch: serial config into a shadow register, atomic commit to the active register.
//  state | meaning
//  IDLE  | no bits loaded since reset/commit/clear
//  SHIFT | partial config in shadow
//  FULL  | shadow complete, waiting for commit; further bits dropped
module switch_box
   import switch_pkg::*;
#(
   parameter int INPUTS  = 8,
   parameter int OUTPUTS = 4,
   parameter int WIDTH   = 1,
   parameter int REG_OUT = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   output logic             cfg_ready,
   output logic             cfg_full,
   input  logic             cfg_commit,
   input  logic             cfg_clear,
   output logic             cfg_err,
   input  logic [WIDTH-1:0] in_data  [INPUTS],
   output logic [WIDTH-1:0] out_data [OUTPUTS]
);

   localparam int FLD_W    = fld_w(INPUTS);
   localparam int CFG_BITS = OUTPUTS * FLD_W;
   localparam int CNT_W    = $clog2(CFG_BITS + 1);

   sb_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CFG_BITS-1:0]  shadow_q, shadow_d;
   logic [CFG_BITS-1:0]  active_q, active_d;
   logic                 err_q, err_d;
   logic                 accept;
   logic                 last_bit;
   logic                 do_commit;
   logic [WIDTH-1:0]     cell_out [OUTPUTS];

   assign accept    = cfg_valid && (state_q != FULL);
   assign last_bit  = (cnt_q == CNT_W'(CFG_BITS - 1));
   assign do_commit = cfg_commit && (state_q == FULL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cfg_clear)      state_d = IDLE;
      else if (do_commit) state_d = IDLE;
      else if (accept)    state_d = last_bit ? FULL : SHIFT;
   end

   always_comb begin
      cfg_ready = (state_q != FULL);
      cfg_full  = (state_q == FULL);
      cfg_err   = err_q;
   end

   // Clear wins over commit, so a clear+commit pair never reports an error.
   always_comb begin
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      err_d    = 1'b0;
      if (cfg_clear) begin
         cnt_d = '0;
      end else if (do_commit) begin
         active_d = shadow_q;
         cnt_d    = '0;
      end else begin
         err_d = cfg_commit;
         if (accept) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], cfg_bit};
            cnt_d    = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         active_q <= '0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         err_q    <= err_d;
      end
   end

   for (genvar o = 0; o < OUTPUTS; o++) begin : g_cell
      switch_box_cell #(
         .INPUTS (INPUTS),
         .WIDTH  (WIDTH),
         .FLD_W  (FLD_W)
      ) u_cell (
         .fld_i     (active_q[o*FLD_W +: FLD_W]),
         .in_data_i (in_data),
         .out_o     (cell_out[o])
      );
   end

   if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] out_q [OUTPUTS];
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int o = 0; o < OUTPUTS; o++) out_q[o] <= '0;
         end else begin
            for (int o = 0; o < OUTPUTS; o++) out_q[o] <= cell_out[o];
         end
      end
      assign out_data = out_q;
   end else begin : g_comb_out
      assign out_data = cell_out;
   end

endmodule

// File: tb/tb_switch_box.sv
// Bench for switch_box: A = 8 inputs combinational out, B = 6 inputs registered out, shared config stream.
module tb_switch_box;

   logic       clk;
   logic       reset_n;
   logic       cfg_valid, cfg_bit, cfg_commit, cfg_clear;
   logic       ready_a, full_a, err_a;
   logic       ready_b, full_b, err_b;
   logic [3:0] in_a  [8];
   logic [3:0] in_b  [6];
   logic [3:0] out_a [4];
   logic [3:0] out_b [4];

   int n_checks = 0;
   int n_errors = 0;

   switch_box #(.INPUTS(8), .OUTPUTS(4), .WIDTH(4), .REG_OUT(0)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_ready(ready_a), .cfg_full(full_a), .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
      .cfg_err(err_a), .in_data(in_a), .out_data(out_a));

   switch_box #(.INPUTS(6), .OUTPUTS(4), .WIDTH(4), .REG_OUT(1)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_ready(ready_b), .cfg_full(full_b), .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
      .cfg_err(err_b), .in_data(in_b), .out_data(out_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: loaded bit string, bit count, full flag, committed config.
   int          m_cnt;
   bit          m_full;
   bit [15:0]   m_shadow;
   bit [15:0]   m_active;
   bit          m_err;
   logic [3:0]  m_outb [4];

   typedef struct {
      logic [15:0] cfg;
      logic [15:0] exp;   // {out3, out2, out1, out0}
   } vec_t;
   vec_t tbl [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] route(input int o, input bit is_b);
      int f, sel, ninp;
      f    = int'((m_active >> (o * 4)) & 16'hF);
      sel  = f % 8;
      ninp = is_b ? 6 : 8;
      if (f < 8 || sel >= ninp) return 4'd0;
      return is_b ? in_b[sel] : in_a[sel];
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_full = 0; m_shadow = '0; m_active = '0; m_err = 0;
      for (int o = 0; o < 4; o++) m_outb[o] = '0;
   endtask

   task automatic model_step();
      logic [3:0] nb [4];
      bit err_n;
      for (int o = 0; o < 4; o++) nb[o] = route(o, 1'b1);
      err_n = 0;
      if (cfg_clear) begin
         m_cnt = 0; m_full = 0;
      end else if (cfg_commit && m_full) begin
         m_active = m_shadow; m_cnt = 0; m_full = 0;
      end else begin
         err_n = cfg_commit;
         if (cfg_valid && !m_full) begin
            m_shadow = {m_shadow[14:0], cfg_bit};
            m_cnt++;
            if (m_cnt == 16) m_full = 1;
         end
      end
      m_err = err_n;
      for (int o = 0; o < 4; o++) m_outb[o] = nb[o];
   endtask

   task automatic check_state();
      chk("ready_a", ready_a, !m_full);
      chk("full_a",  full_a,  m_full);
      chk("err_a",   err_a,   m_err);
      chk("ready_b", ready_b, !m_full);
      chk("full_b",  full_b,  m_full);
      chk("err_b",   err_b,   m_err);
      for (int o = 0; o < 4; o++) begin
         chk($sformatf("out_a[%0d]", o), out_a[o], route(o, 1'b0));
         chk($sformatf("out_b[%0d]", o), out_b[o], m_outb[o]);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_state();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      cfg_valid = 1'b1; cfg_bit = b;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic load(input logic [15:0] w, input int nbits);
      for (int i = 15; i > 15 - nbits; i--) send_bit(w[i]);
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      for (int o = 0; o < 4; o++) begin
         chk($sformatf("rst out_a[%0d]", o), out_a[o], 4'd0);
         chk($sformatf("rst out_b[%0d]", o), out_b[o], 4'd0);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic fixed_inputs();
      for (int i = 0; i < 8; i++) in_a[i] = 4'(i + 1);
      for (int i = 0; i < 6; i++) in_b[i] = 4'(i + 1);
   endtask

   initial begin
      tbl[0] = '{cfg: 16'b1111_1000_0000_1101, exp: 16'h8106};
      tbl[1] = '{cfg: 16'h0000,                exp: 16'h0000};
      tbl[2] = '{cfg: 16'h9ABC,                exp: 16'h2345};
      tbl[3] = '{cfg: 16'h7F0E,                exp: 16'h0807};

      cfg_valid = 0; cfg_bit = 0; cfg_commit = 0; cfg_clear = 0;
      reset_n = 0;
      fixed_inputs();
      model_reset();

      // reset state
      do_reset();
      tick();
      chk("ready after reset", ready_a, 1'b1);
      chk("full after reset", full_a, 1'b0);

      // routing vectors
      for (int v = 0; v < 4; v++) begin
         load(tbl[v].cfg, 16);
         chk("full after 16 bits", full_a, 1'b1);
         commit();
         chk("ready after commit", ready_a, 1'b1);
         for (int o = 0; o < 4; o++)
            chk($sformatf("vec%0d out_a[%0d]", v, o), out_a[o], tbl[v].exp[o*4 +: 4]);
         tick();
      end

      // early commit: error pulse, load continues
      load(16'h9ABC, 10);
      commit();
      chk("early commit err", err_a, 1'b1);
      chk("early commit out3", out_a[3], 4'd0);
      tick();
      chk("err one cycle", err_a, 1'b0);
      for (int i = 5; i >= 0; i--) send_bit(tbl[2].cfg[i]);
      chk("full after 6 more", full_a, 1'b1);

      // bits while full are dropped; commit applies the original load
      repeat (3) send_bit(1'b0);
      chk("ready while full", ready_a, 1'b0);
      commit();
      for (int o = 0; o < 4; o++)
         chk($sformatf("after drop out_a[%0d]", o), out_a[o], tbl[2].exp[o*4 +: 4]);

      // clear beats commit
      load(16'h8106, 16);
      cfg_clear = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_clear = 1'b0; cfg_commit = 1'b0;
      chk("clear full", full_a, 1'b0);
      chk("clear keeps out2", out_a[2], 4'd3);
      tick();
      chk("clear no err", err_a, 1'b0);

      // async reset mid-load, then a full reload
      load(tbl[0].cfg, 7);
      do_reset();
      tick();
      load(tbl[0].cfg, 16);
      commit();
      for (int o = 0; o < 4; o++)
         chk($sformatf("reload out_a[%0d]", o), out_a[o], tbl[0].exp[o*4 +: 4]);

      // registered output with 6 inputs: out-of-range select drives 0
      do_reset();
      tick();
      load(16'hED00, 16);
      commit();
      chk("regout before", out_b[2], 4'd0);
      tick();
      chk("regout out2", out_b[2], 4'd6);
      chk("regout sel6", out_b[3], 4'd0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 8; i++) in_a[i] = 4'($urandom);
         for (int i = 0; i < 6; i++) in_b[i] = 4'($urandom);
         cfg_valid  = ($urandom % 4) != 0;
         cfg_bit    = 1'($urandom);
         cfg_commit = ($urandom % 12) == 0;
         cfg_clear  = ($urandom % 80) == 0;
         tick();
      end
      cfg_valid = 0; cfg_commit = 0; cfg_clear = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
